b11_feeder: RTL and testbench
=============================

Name: b11_feeder

Overview:
- Transmit-side driver for the b11 scrambler's serial input handshake (6-bit symbol + active-low strobe).
- Accepts symbols from an upstream producer into a small FIFO.
- Presents each symbol to the b11 core as a one-cycle strobe-low pulse, then holds the line quiet for a programmable gap so the core can finish its computation path before the next symbol.
- Sits directly in front of the b11 core and owns its input side.

Parameters:
- DEPTH, 8: FIFO depth in symbols; power of two, minimum 2.
- GAP_DEFAULT, 16: hold cycles used when gap_cfg is 0. Covers the worst-case b11 path from state 2 back to state 1, including the state 5/6 loops.
- WARMUP, 2: cycles after reset release before the first strobe. Covers the b11 state 0 → state 1 transition.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- push_valid, in, 1: upstream symbol valid.
- push_data, in, 6: upstream symbol.
- push_ready, out, 1: FIFO not full.
- gap_cfg, in, 8: hold length in cycles; 0 selects GAP_DEFAULT. Sampled when entering PRESENT.
- x_in, out, 6: symbol to the b11 core.
- stbi, out, 1: strobe to the b11 core. Low means "sample now".
- busy, out, 1: high in WARM, PRESENT or HOLD.
- fifo_count, out, $clog2(DEPTH)+1: current FIFO occupancy.
- sent_count, out, 16: symbols issued; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, any state) forces:
  - stbi=1, x_in=0, busy=1, push_ready=0, fifo_count=0, sent_count=0.
  - FIFO emptied, gap counter cleared, state=WARM.
- Reset asserted mid-PRESENT or mid-HOLD abandons the symbol in flight. It is not re-sent and not counted.
- All outputs are registered. stbi and x_in never glitch.
- States:
  - WARM: stbi=1. Counts WARMUP cycles, then goes to IDLE. push_ready is 0 in WARM.
  - IDLE: stbi=1, x_in holds its last value. If the FIFO is non-empty, pop the head and go to PRESENT on the next edge.
  - PRESENT (exactly 1 cycle): stbi=0, x_in=popped symbol. Latch hold = (gap_cfg==0 ? GAP_DEFAULT : gap_cfg). Increment sent_count. Go to HOLD.
  - HOLD: stbi=1, x_in unchanged (the b11 core resamples x_in while in state 1, so it must stay stable). Decrement the counter each cycle; after `hold` cycles go to IDLE.
- Throughput: with a back-to-back FIFO, strobes are spaced exactly hold+2 cycles apart (PRESENT, hold cycles of HOLD, 1 cycle of IDLE).
- Latency: a symbol pushed into an empty FIFO while the FSM is in IDLE gets stbi low 2 cycles after the push edge.
- FIFO:
  - push_ready = !full. No write bypass when full.
  - Simultaneous push and pop at full is not accepted, because push_ready is already 0.
  - Simultaneous push and pop at count 1 is legal: count stays 1.
  - Push when push_valid && push_ready.
  - Pointers wrap modulo DEPTH. fifo_count is exact at all times.
- gap_cfg changes during HOLD have no effect until the next PRESENT.
- stbi is never low on two consecutive cycles.
- stbi is never low while in WARM.

Optional Feature:
- Macro: B11_FEEDER_FILTER_EN.
- Defined:
  - On pop, symbols the core would reject (value >26 and not 0 or 63) are discarded without a strobe. The FSM stays in IDLE and pops the next entry on the next cycle.
  - Adds output drop_count (8 bits, saturating at 255, reset 0).
  - sent_count counts only issued symbols.
- Undefined: every symbol is issued, and the drop_count port is absent.

Decomposition:
- Package b11_feeder_pkg holds:
  - SYM_W=6 and symbol typedef sym_t.
  - FSM enum state_t {WARM, IDLE, PRESENT, HOLD}.
  - GAP_W=8.
  - Reject-predicate function is_reject(sym_t), used only under the macro.
- One sub-module, b11_feeder_fifo: parameterized DEPTH register FIFO with count output.
- FSM, gap counter and sent counter live in the top module.

Test Plan:
- Reset, then idle: stbi=1 for all cycles, no low pulse in the first 2 cycles, push_ready rises on cycle 3, x_in=0.
- Push 6'h05 with gap_cfg=4 into idle: stbi low exactly 1 cycle with x_in=5, 2 cycles after the push. x_in stays 5 for the next 4 cycles. sent_count=1.
- Push 8 symbols back-to-back with gap_cfg=0: push_ready drops after the 8th. Strobes are spaced 18 cycles apart (GAP_DEFAULT+2). Order is preserved and sent_count=8.
- Assert reset during HOLD of symbol 2 of 4: stbi=1 and fifo_count=0 immediately, sent_count=0, no further strobes until new pushes.
- Change gap_cfg from 3 to 10 mid-HOLD: current spacing stays 5 cycles, next spacing is 12 cycles.
- With B11_FEEDER_FILTER_EN, push 6'h1F, 6'h3F, 6'h1B, 6'h02: strobes only for 0x3F and 0x02, drop_count=2, sent_count=2.

Source files
------------

// File: rtl/b11_feeder_pkg.sv
// ---------------------------------------------------------------------------
// b11_feeder_pkg
// Shared types and helpers for the b11 scrambler input feeder.
//   SYM_W / sym_t : width and type of one b11 input symbol
//   GAP_W         : width of the programmable hold (gap) length
//   state_t       : feeder FSM states
//   is_reject()   : symbols the b11 core would refuse (filter build only)
// ---------------------------------------------------------------------------
package b11_feeder_pkg;

    localparam int SYM_W = 6;
    localparam int GAP_W = 8;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        WARM    = 2'd0,
        IDLE    = 2'd1,
        PRESENT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // The core only accepts 0..26 plus the two escape codes 0 and 63.
    function automatic logic is_reject(input sym_t s);
        return (s > sym_t'(26)) && (s != sym_t'(0)) && (s != sym_t'(63));
    endfunction

endpackage

// File: rtl/b11_feeder_fifo.sv
// ---------------------------------------------------------------------------
// b11_feeder_fifo
// Small register FIFO holding symbols waiting to be presented to the core.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   push, push_data   : write strobe (caller guarantees not full) and symbol
//   pop               : read strobe (caller guarantees not empty)
//   head              : symbol at the read pointer (valid while count != 0)
//   count             : registered occupancy, exact at all times
//   count_next        : occupancy after the current edge (for registered
//                       full/ready flags in the parent)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module b11_feeder_fifo
    import b11_feeder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [SYM_W-1:0]       push_data,
    input  logic                   pop,
    output logic [SYM_W-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sym_t          mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    // Storage carries no reset: stale entries are never visible because
    // head is only consumed while count is non-zero.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/b11_feeder.sv
// ---------------------------------------------------------------------------
// b11_feeder
// Drives the b11 scrambler's serial input handshake. Symbols from an
// upstream producer are queued; each one is shown to the core as a single
// stbi-low cycle, followed by a quiet hold so the core can finish its
// processing path before the next symbol arrives.
// Ports:
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   push_valid/data : upstream symbol offer
//   push_ready      : FIFO has room (held low during warm-up)
//   gap_cfg         : hold cycles after each strobe, 0 = GAP_DEFAULT;
//                     sampled as a symbol is issued
//   x_in, stbi      : symbol and active-low strobe to the b11 core
//   busy            : high in WARM, PRESENT and HOLD
//   fifo_count      : FIFO occupancy
//   sent_count      : symbols issued, wraps at 2^16
//   drop_count      : rejected symbols, saturating (filter build only)
// Build option: define B11_FEEDER_FILTER_EN to discard symbols the core
// would reject instead of issuing them.
// All outputs come straight from flops so stbi/x_in cannot glitch.
// ---------------------------------------------------------------------------
module b11_feeder
    import b11_feeder_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int GAP_DEFAULT = 16,
    parameter int WARMUP      = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_valid,
    input  logic [SYM_W-1:0]       push_data,
    output logic                   push_ready,
    input  logic [GAP_W-1:0]       gap_cfg,
    output logic [SYM_W-1:0]       x_in,
    output logic                   stbi,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            sent_count
`ifdef B11_FEEDER_FILTER_EN
    ,
    output logic [7:0]             drop_count
`endif
);

    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int WARM_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    state_t            state_reg;
    state_t            state_next;
    logic [WARM_W-1:0] warm_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [GAP_W-1:0]  gap_load;
    logic [15:0]       sent_count_reg;

    sym_t              head;
    logic [CW-1:0]     fifo_count_next;
    logic              push;
    logic              pop;
    logic              head_reject;
    logic              issue;

    logic              stbi_reg, stbi_next;
    logic              busy_reg, busy_next;
    logic              push_ready_reg, push_ready_next;
    sym_t              x_in_reg, x_in_next;

    // -----------------------------------------------------------------------
    // Queue
    // -----------------------------------------------------------------------
    assign push = push_valid && push_ready_reg;
    // Pops happen only from IDLE; a popped symbol either becomes a strobe
    // (issue) or, in the filter build, is dropped while staying in IDLE.
    assign pop   = (state_reg == IDLE) && (fifo_count != '0);
    assign issue = pop && !head_reject;

    b11_feeder_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

`ifdef B11_FEEDER_FILTER_EN
    logic [7:0] drop_count_reg;

    assign head_reject = is_reject(head);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count_reg <= '0;
        end else if (pop && head_reject && (drop_count_reg != 8'hFF)) begin
            drop_count_reg <= drop_count_reg + 8'd1;
        end
    end

    assign drop_count = drop_count_reg;
`else
    assign head_reject = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= WARM;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WARM:    if (warm_cnt_reg == WARM_W'(WARMUP - 1)) state_next = IDLE;
            IDLE:    if (issue) state_next = PRESENT;
            PRESENT: state_next = HOLD;
            // gap_cnt_reg is loaded with the hold length on issue and counts
            // down once per HOLD cycle, so HOLD lasts exactly that many cycles.
            HOLD:    if (gap_cnt_reg == GAP_W'(1)) state_next = IDLE;
            default: state_next = WARM;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs, decoded from the next state so the registered copies
    // line up with the state they describe.
    // -----------------------------------------------------------------------
    always_comb begin
        stbi_next       = (state_next != PRESENT);
        busy_next       = (state_next != IDLE);
        push_ready_next = (state_next != WARM) && (fifo_count_next != CW'(DEPTH));
        // x_in only changes when a symbol is issued; it stays put through
        // HOLD and IDLE because the core keeps resampling it.
        x_in_next       = issue ? head : x_in_reg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stbi_reg       <= 1'b1;
            busy_reg       <= 1'b1;
            push_ready_reg <= 1'b0;
            x_in_reg       <= '0;
        end else begin
            stbi_reg       <= stbi_next;
            busy_reg       <= busy_next;
            push_ready_reg <= push_ready_next;
            x_in_reg       <= x_in_next;
        end
    end

    // -----------------------------------------------------------------------
    // Warm-up, gap and sent counters
    // -----------------------------------------------------------------------
    assign gap_load = (gap_cfg == '0) ? GAP_W'(GAP_DEFAULT) : gap_cfg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            warm_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            sent_count_reg <= '0;
        end else begin
            if (state_reg == WARM) begin
                warm_cnt_reg <= warm_cnt_reg + WARM_W'(1);
            end
            if (issue) begin
                gap_cnt_reg    <= gap_load;
                sent_count_reg <= sent_count_reg + 16'd1;
            end else if (state_reg == HOLD) begin
                gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
            end
        end
    end

    assign stbi       = stbi_reg;
    assign busy       = busy_reg;
    assign push_ready = push_ready_reg;
    assign x_in       = x_in_reg;
    assign sent_count = sent_count_reg;

endmodule

// File: tb/tb_b11_feeder.sv
// ---------------------------------------------------------------------------
// tb_b11_feeder
// Directed bench for b11_feeder. Outputs are sampled on the falling edge,
// inputs are driven right after the falling edge. A monitor logs every
// stbi-low cycle (cycle number and x_in) so strobe spacing and order can be
// checked against hand-computed values.
// Honours B11_FEEDER_FILTER_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_b11_feeder;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic          push_valid = 1'b0;
    logic [5:0]    push_data  = '0;
    logic [7:0]    gap_cfg    = '0;
    logic          push_ready;
    logic [5:0]    x_in;
    logic          stbi;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic [15:0]   sent_count;
`ifdef B11_FEEDER_FILTER_EN
    logic [7:0]    drop_count;
`endif

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic       prev_low = 1'b0;
    int         strb_t[$];
    logic [5:0] strb_x[$];

    always #5 clock = ~clock;

    b11_feeder #(
        .DEPTH       (DEPTH),
        .GAP_DEFAULT (16),
        .WARMUP      (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .gap_cfg    (gap_cfg),
        .x_in       (x_in),
        .stbi       (stbi),
        .busy       (busy),
        .fifo_count (fifo_count),
        .sent_count (sent_count)
`ifdef B11_FEEDER_FILTER_EN
        ,
        .drop_count (drop_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Strobe logger; also flags two low cycles in a row.
    always @(negedge clock) begin
        cyc++;
        if (!reset && stbi === 1'b0) begin
            check_eq("stbi_not_consecutive", prev_low, 1'b0);
            strb_t.push_back(cyc);
            strb_x.push_back(x_in);
        end
        prev_low = !reset && (stbi === 1'b0);
    end

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k = 0;
        while (strb_x.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        check_eq(tag, strb_x.size(), n);
    endtask

    task automatic wait_low(input int budget, input string tag);
        int k = 0;
        while (stbi !== 1'b0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        check_eq(tag, stbi, 1'b0);
    endtask

    // Push a list of symbols on consecutive edges (caller ensures room).
    task automatic push_list(input logic [5:0] syms[$]);
        foreach (syms[i]) begin
            push_data  = syms[i];
            push_valid = 1'b1;
            @(negedge clock);
        end
        push_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int base;
        int sc0;
        logic [5:0] burst[$];
        logic [5:0] four[$];
        logic [5:0] trio[$];

        burst = '{6'h01, 6'h0A, 6'h13, 6'h1A, 6'h00, 6'h3F, 6'h15, 6'h07};
        four  = '{6'h21 & 6'h1F, 6'h02, 6'h03, 6'h04};
        trio  = '{6'h11, 6'h12, 6'h13};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        check_eq("rst_stbi", stbi, 1'b1);
        check_eq("rst_x_in", x_in, 6'h00);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_push_ready", push_ready, 1'b0);
        check_eq("rst_fifo_count", fifo_count, 0);
        check_eq("rst_sent_count", sent_count, 0);

        // Release; WARM covers this cycle and the next, ready on the third.
        reset = 1'b0;
        @(negedge clock);
        check_eq("warm_push_ready", push_ready, 1'b0);
        check_eq("warm_busy", busy, 1'b1);
        @(negedge clock);
        check_eq("warm_done_push_ready", push_ready, 1'b1);
        check_eq("warm_done_busy", busy, 1'b0);
        repeat (10) @(negedge clock);
        check_eq("idle_no_strobe", strb_x.size(), 0);
        check_eq("idle_stbi", stbi, 1'b1);
        check_eq("idle_x_in", x_in, 6'h00);

        // ---------------- single symbol, gap 4 ----------------
        gap_cfg    = 8'd4;
        push_data  = 6'h05;
        push_valid = 1'b1;
        @(negedge clock);                    // push edge has passed
        push_valid = 1'b0;
        check_eq("t2_fifo_count", fifo_count, 1);
        check_eq("t2_stbi_pre", stbi, 1'b1);
        @(negedge clock);                    // second cycle after push
        check_eq("t2_strobe", stbi, 1'b0);
        check_eq("t2_x_in", x_in, 6'h05);
        check_eq("t2_sent", sent_count, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            check_eq($sformatf("t2_hold%0d_stbi", k), stbi, 1'b1);
            check_eq($sformatf("t2_hold%0d_x_in", k), x_in, 6'h05);
            check_eq($sformatf("t2_hold%0d_busy", k), busy, 1'b1);
        end
        @(negedge clock);
        check_eq("t2_idle_busy", busy, 1'b0);
        check_eq("t2_idle_x_in", x_in, 6'h05);

        // ---------------- back-to-back burst, default gap ----------------
        // A lead symbol starts a 16-cycle hold; the 8-symbol burst lands
        // during that hold so the FIFO fills completely.
        gap_cfg = 8'd0;
        base    = strb_x.size();
        sc0     = sent_count;
        push_data  = 6'h09;
        push_valid = 1'b1;
        @(negedge clock);
        push_valid = 1'b0;
        wait_low(10, "t3_lead_strobe");
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t3_ready%0d", i), push_ready, 1'b1);
            push_data  = burst[i];
            push_valid = 1'b1;
            @(negedge clock);
        end
        push_valid = 1'b0;
        check_eq("t3_full_ready", push_ready, 1'b0);
        check_eq("t3_full_count", fifo_count, 8);
        wait_strobes(base + 9, 250, "t3_strobe_total");
        if (strb_x.size() >= base + 9) begin
            for (int i = 0; i < 8; i++) begin
                check_eq($sformatf("t3_order%0d", i), strb_x[base + 1 + i], burst[i]);
                check_eq($sformatf("t3_spacing%0d", i),
                         strb_t[base + 1 + i] - strb_t[base + i], 18);
            end
        end
        check_eq("t3_sent", sent_count, (sc0 + 9) & 16'hFFFF);
        repeat (20) @(negedge clock);

        // ---------------- reset during HOLD of symbol 2 of 4 ----------------
        gap_cfg = 8'd4;
        base    = strb_x.size();
        push_list(four);
        wait_strobes(base + 2, 40, "t4_two_strobes");
        @(negedge clock);
        check_eq("t4_in_hold_busy", busy, 1'b1);
        check_eq("t4_pending", fifo_count, 2);
        #1 reset = 1'b1;
        #1;
        check_eq("t4_rst_stbi", stbi, 1'b1);
        check_eq("t4_rst_fifo_count", fifo_count, 0);
        check_eq("t4_rst_sent", sent_count, 0);
        check_eq("t4_rst_push_ready", push_ready, 1'b0);
        check_eq("t4_rst_x_in", x_in, 6'h00);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check_eq("t4_no_more_strobes", strb_x.size(), base + 2);
        check_eq("t4_sent_after", sent_count, 0);
        check_eq("t4_fifo_after", fifo_count, 0);

        // ---------------- gap change mid-HOLD ----------------
        gap_cfg = 8'd3;
        base    = strb_x.size();
        push_list(trio);
        @(negedge clock);                    // inside the first symbol's hold
        check_eq("t5_first_seen", strb_x.size(), base + 1);
        check_eq("t5_in_hold_stbi", stbi, 1'b1);
        gap_cfg = 8'd10;
        wait_strobes(base + 3, 60, "t5_strobe_total");
        if (strb_x.size() >= base + 3) begin
            check_eq("t5_spacing_old", strb_t[base + 1] - strb_t[base], 5);
            check_eq("t5_spacing_new", strb_t[base + 2] - strb_t[base + 1], 12);
            check_eq("t5_sym_c", strb_x[base + 2], 6'h13);
        end
        repeat (15) @(negedge clock);

`ifdef B11_FEEDER_FILTER_EN
        // ---------------- reject filter ----------------
        begin
            logic [5:0] mix[$];
            mix     = '{6'h1F, 6'h3F, 6'h1B, 6'h02};
            gap_cfg = 8'd4;
            base    = strb_x.size();
            sc0     = sent_count;
            check_eq("t6_drop_before", drop_count, 0);
            push_list(mix);
            wait_strobes(base + 2, 60, "t6_strobe_total");
            repeat (15) @(negedge clock);
            check_eq("t6_only_two", strb_x.size(), base + 2);
            if (strb_x.size() >= base + 2) begin
                check_eq("t6_first", strb_x[base], 6'h3F);
                check_eq("t6_second", strb_x[base + 1], 6'h02);
            end
            check_eq("t6_drop", drop_count, 2);
            check_eq("t6_sent", sent_count, (sc0 + 2) & 16'hFFFF);
        end
`else
        // ---------------- out-of-range symbol still issued ----------------
        gap_cfg    = 8'd4;
        base       = strb_x.size();
        push_data  = 6'h2A;
        push_valid = 1'b1;
        @(negedge clock);
        push_valid = 1'b0;
        wait_strobes(base + 1, 10, "t6_strobe");
        if (strb_x.size() >= base + 1) begin
            check_eq("t6_x_in", strb_x[base], 6'h2A);
        end
        repeat (10) @(negedge clock);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
